// File: rtl/fb_arb_pkg.sv
// Shared types for the frame-buffer port arbiter: requester tags and arbitration states.
package fb_arb_pkg;

  typedef enum logic [1:0] {
    ID_NONE = 2'd0,
    ID_VGA  = 2'd1,
    ID_BLT  = 2'd2,
    ID_CPU  = 2'd3
  } req_id_t;

  typedef enum logic [1:0] {
    RR_BLT = 2'd0,
    RR_CPU = 2'd1,
    LOCK   = 2'd2
  } arb_state_t;

endpackage

// File: rtl/fb_rd_tag_pipe.sv
// Fixed-latency shift register of requester tags; the head names the owner of mem_rdata.
module fb_rd_tag_pipe
  import fb_arb_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic    clk,
  input  logic    rst_n,
  input  req_id_t tag_in,
  output req_id_t tag_out
);

  req_id_t stages [DEPTH];

  // NOTE: this array is a handful of flops, not a RAM, so it is cleared on reset;
  // that is what drops in-flight reads when reset hits mid-operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= ID_NONE;
    end else begin
      stages[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port frame-buffer arbiter: VGA strict priority, blitter/CPU round-robin with
// bounded blitter burst lock, registered memory command and tagged read-data return.
module fb_port_arbiter
  import fb_arb_pkg::*;
#(
  parameter int AW        = 20,
  parameter int DW        = 16,
  parameter int RD_LAT    = 2,
  parameter int BURST_MAX = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vga_req,
  input  logic [AW-1:0] vga_addr,
  output logic          vga_gnt,
  output logic          vga_rvalid,
  input  logic          blt_req,
  input  logic          blt_we,
  input  logic          blt_lock,
  input  logic [AW-1:0] blt_addr,
  input  logic [DW-1:0] blt_wdata,
  output logic          blt_gnt,
  output logic          blt_rvalid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int CW = $clog2(BURST_MAX + 1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] burst_q, burst_d, burst_inc;
  logic          any_gnt, sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  req_id_t       push_tag, head_tag;

  // NOTE: every output of a combinational block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    vga_gnt = 1'b0;
    blt_gnt = 1'b0;
    cpu_gnt = 1'b0;
    if (rst_n) begin
      if (vga_req)                 vga_gnt = 1'b1;
      else if (state_q == LOCK)    blt_gnt = blt_req;
      else if (state_q == RR_CPU) begin
        if (cpu_req) cpu_gnt = 1'b1;
        else         blt_gnt = blt_req;
      end else begin
        if (blt_req) blt_gnt = 1'b1;
        else         cpu_gnt = cpu_req;
      end
    end
  end

  assign burst_inc = burst_q + 1'b1;

  // VGA grants leave state and burst count untouched, so a preemption never ends a lock.
  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
    case (state_q)
      RR_BLT, RR_CPU: begin
        if (cpu_gnt) begin
          state_d = RR_BLT;
        end else if (blt_gnt) begin
          if (blt_lock && (BURST_MAX > 1)) begin
            state_d = LOCK;
            burst_d = CW'(1);
          end else begin
            state_d = RR_CPU;
          end
        end
      end
      LOCK: begin
        if (blt_gnt) begin
          if (!blt_lock || burst_inc == CW'(BURST_MAX)) begin
            state_d = RR_CPU;
            burst_d = '0;
          end else begin
            burst_d = burst_inc;
          end
        end else if (!vga_gnt && !blt_req) begin
          state_d = RR_CPU;
          burst_d = '0;
        end
      end
      default: begin
        state_d = RR_BLT;
        burst_d = '0;
      end
    endcase
  end

  // Command mux; writes push ID_NONE since they never return data.
  always_comb begin
    any_gnt   = vga_gnt | blt_gnt | cpu_gnt;
    sel_addr  = vga_addr;
    sel_wdata = blt_wdata;
    sel_we    = 1'b0;
    push_tag  = ID_NONE;
    if (vga_gnt) begin
      push_tag = ID_VGA;
    end else if (blt_gnt) begin
      sel_addr  = blt_addr;
      sel_wdata = blt_wdata;
      sel_we    = blt_we;
      push_tag  = blt_we ? ID_NONE : ID_BLT;
    end else if (cpu_gnt) begin
      sel_addr  = cpu_addr;
      sel_wdata = cpu_wdata;
      sel_we    = cpu_we;
      push_tag  = cpu_we ? ID_NONE : ID_CPU;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RR_BLT;
      burst_q   <= '0;
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      mem_ce  <= any_gnt;
      mem_we  <= sel_we;
      if (any_gnt) begin
        mem_addr <= sel_addr;
        if (!vga_gnt) mem_wdata <= sel_wdata;
      end
    end
  end

  fb_rd_tag_pipe #(.DEPTH(RD_LAT + 1)) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .tag_in  (push_tag),
    .tag_out (head_tag)
  );

  assign vga_rvalid = (head_tag == ID_VGA);
  assign blt_rvalid = (head_tag == ID_BLT);
  assign cpu_rvalid = (head_tag == ID_CPU);
  assign rdata      = mem_rdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: directed scenarios plus randomized traffic
// checked against a behavioural arbitration/memory model.
module tb_fb_port_arbiter;
  localparam int AW = 20, DW = 16, RD_LAT = 2, BURST_MAX = 8;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          vga_req = 0, blt_req = 0, blt_we = 0, blt_lock = 0, cpu_req = 0, cpu_we = 0;
  logic [AW-1:0] vga_addr = '0, blt_addr = '0, cpu_addr = '0;
  logic [DW-1:0] blt_wdata = '0, cpu_wdata = '0;
  logic          vga_gnt, blt_gnt, cpu_gnt, vga_rvalid, blt_rvalid, cpu_rvalid;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, rdata, mem_rdata;

  fb_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .BURST_MAX(BURST_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid),
    .blt_req(blt_req), .blt_we(blt_we), .blt_lock(blt_lock), .blt_addr(blt_addr),
    .blt_wdata(blt_wdata), .blt_gnt(blt_gnt), .blt_rvalid(blt_rvalid),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .rdata(rdata),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #10 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0, last_g = 0;
  initial forever @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
    return a[15:0] * 16'h9E37 ^ {a[19:16], 12'h5A5};
  endfunction

  // Memory with RD_LAT cycles from command to data.
  logic [DW-1:0] dl [RD_LAT];
  always @(posedge clk) begin
    dl[0] <= (mem_ce && !mem_we) ? mem_val(mem_addr) : 16'hDEAD;
    for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
  end
  assign mem_rdata = dl[RD_LAT-1];

  typedef struct { int due; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } mem_exp_t;
  typedef struct { int due; int id; logic [DW-1:0] data; } rd_exp_t;
  mem_exp_t mem_q[$];
  rd_exp_t  rd_q[$];

  function automatic int gnt_code();
    case ({vga_gnt, blt_gnt, cpu_gnt})
      3'b000:  return 0;
      3'b100:  return 1;
      3'b010:  return 2;
      3'b001:  return 3;
      default: return 7;
    endcase
  endfunction

  // Reference model: who wins, and what the memory port and read return must show later.
  bit m_pref_cpu = 0, m_locked = 0;
  int m_run = 0;
  initial begin : model
    int g;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    forever begin
      @(negedge clk);
      g = 0;
      if (!rst_n) begin
        m_pref_cpu = 0; m_locked = 0; m_run = 0;
        mem_q.delete(); rd_q.delete();
      end else if (vga_req)   g = 1;
      else if (m_locked)      g = blt_req ? 2 : 0;
      else if (m_pref_cpu)    g = cpu_req ? 3 : (blt_req ? 2 : 0);
      else                    g = blt_req ? 2 : (cpu_req ? 3 : 0);
      check("grant", gnt_code(), g);
      last_g = g;
      if (rst_n && g != 0) begin
        we = (g == 2) ? blt_we : (g == 3) ? cpu_we : 1'b0;
        a  = (g == 1) ? vga_addr : (g == 2) ? blt_addr : cpu_addr;
        wd = (g == 2) ? blt_wdata : cpu_wdata;
        mem_q.push_back('{cyc + 1, we, a, wd});
        if (!we) rd_q.push_back('{cyc + 1 + RD_LAT, g, mem_val(a)});
      end
      if (rst_n) begin
        if (g == 2) begin
          if (!m_locked && blt_lock) begin m_locked = 1; m_run = 0; end
          if (m_locked) begin
            m_run++;
            if (!blt_lock || m_run >= BURST_MAX) begin m_locked = 0; m_run = 0; m_pref_cpu = 1; end
          end else m_pref_cpu = 1;
        end else if (g == 3) m_pref_cpu = 0;
        else if (g == 0 && m_locked && !blt_req) begin m_locked = 0; m_run = 0; m_pref_cpu = 1; end
      end
    end
  end

  // Monitor: compares the memory port and read returns against the queued expectations.
  initial begin : monitor
    mem_exp_t      e;
    rd_exp_t       r;
    logic [AW-1:0] last_addr;
    int            nv;
    last_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_addr = '0;
      end else begin
        if (mem_ce) begin
          if (mem_q.size() == 0) check("mem_ce_unexpected", 1, 0);
          else begin
            e = mem_q.pop_front();
            check("mem_due", cyc, e.due);
            check("mem_we", mem_we, e.we);
            check("mem_addr", mem_addr, e.addr);
            if (e.we) check("mem_wdata", mem_wdata, e.wdata);
            last_addr = e.addr;
          end
        end else begin
          check("mem_we_idle", mem_we, 0);
          check("mem_addr_hold", mem_addr, last_addr);
          if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            check("mem_ce_missing", 0, 1);
            void'(mem_q.pop_front());
          end
        end
        nv = int'(vga_rvalid) + int'(blt_rvalid) + int'(cpu_rvalid);
        if (nv > 1) check("rvalid_onehot", nv, 1);
        else if (nv == 1) begin
          if (rd_q.size() == 0) check("rvalid_unexpected", 1, 0);
          else begin
            r = rd_q.pop_front();
            check("rvalid_due", cyc, r.due);
            check("rvalid_id", vga_rvalid ? 1 : blt_rvalid ? 2 : 3, r.id);
            check("rdata", rdata, r.data);
          end
        end else if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
          check("rvalid_missing", 0, 1);
          void'(rd_q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    vga_req = 0; blt_req = 0; cpu_req = 0; blt_we = 0; cpu_we = 0; blt_lock = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_mem_ce"}, mem_ce, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_rvalid"}, {vga_rvalid, blt_rvalid, cpu_rvalid}, 0);
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 0;
    check_reset_outputs("rst");
    step();
    rst_n = 1;
  endtask

  task automatic rand_cycle(input int p_vga);
    if (!vga_req || last_g == 1) begin
      vga_req = ($urandom_range(0, 99) < p_vga); vga_addr = AW'($urandom);
    end
    if (!blt_req || last_g == 2) begin
      blt_req = ($urandom_range(0, 99) < 60); blt_addr = AW'($urandom);
      blt_we = $urandom_range(0, 2) == 0; blt_wdata = DW'($urandom);
      blt_lock = $urandom_range(0, 3) != 0;
    end
    if (!cpu_req || last_g == 3) begin
      cpu_req = ($urandom_range(0, 99) < 50); cpu_addr = AW'($urandom);
      cpu_we = $urandom_range(0, 2) == 0; cpu_wdata = DW'($urandom);
    end
    step();
  endtask

  int seq[4], n_blt;
  bit seen_cpu;

  initial begin
    #1;
    do_reset();
    step();

    // CPU read at 0x00010 out of reset.
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h00010;
    @(negedge clk); check("t1_cpu_gnt", cpu_gnt, 1);
    step(); cpu_req = 0;
    repeat (5) step();

    // All three requesting: VGA x6, then BLT/CPU alternate.
    do_reset(); step();
    vga_req = 1; blt_req = 1; cpu_req = 1; blt_lock = 0; blt_we = 0; cpu_we = 0;
    for (int i = 0; i < 6; i++) begin vga_addr = AW'(i); step(); end
    vga_req = 0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); seq[i] = gnt_code(); step(); end
    check("t2_seq0", seq[0], 2); check("t2_seq1", seq[1], 3);
    check("t2_seq2", seq[2], 2); check("t2_seq3", seq[3], 3);
    idle_all(); repeat (5) step();

    // Burst lock with a VGA preemption mid-burst.
    do_reset(); step();
    blt_req = 1; blt_lock = 1; blt_we = 0; cpu_req = 1; cpu_we = 0;
    n_blt = 0; seen_cpu = 0;
    for (int i = 0; i < 16; i++) begin
      vga_req = (i == 3); vga_addr = 20'h00ABC; blt_addr = AW'(20'h1000 + i);
      @(negedge clk);
      if (!seen_cpu) begin
        if (blt_gnt) n_blt++;
        if (cpu_gnt) seen_cpu = 1;
      end
      step();
    end
    check("t3_burst_len", n_blt, BURST_MAX);
    check("t3_cpu_after_burst", seen_cpu, 1);
    idle_all(); repeat (5) step();

    // Interleaved reads VGA 0x100, CPU 0x200, VGA 0x101.
    vga_req = 1; vga_addr = 20'h00100; cpu_req = 1; cpu_addr = 20'h00200; step();
    vga_req = 0; step();
    cpu_req = 0; vga_req = 1; vga_addr = 20'h00101; step();
    idle_all(); repeat (5) step();

    // Blitter write: fire-and-forget.
    blt_req = 1; blt_we = 1; blt_addr = 20'h003FF; blt_wdata = 16'hBEEF; step();
    idle_all();
    @(negedge clk);
    check("t5_mem_we", mem_we, 1); check("t5_mem_wdata", mem_wdata, 16'hBEEF);
    repeat (5) step();

    // Reset one cycle after a CPU read grant discards the read.
    cpu_req = 1; cpu_we = 0; cpu_addr = 20'h0002A; step();
    idle_all(); rst_n = 0;
    check_reset_outputs("t6");
    step(); step(); rst_n = 1;
    check_reset_outputs("t6_rel");
    repeat (6) step();
    blt_req = 1; cpu_req = 1;
    @(negedge clk); check("t6_restart_blt_first", gnt_code(), 2);
    step(); idle_all(); repeat (5) step();

    // Randomized traffic with a reset in the middle.
    for (int i = 0; i < 1000; i++) rand_cycle(20);
    do_reset();
    for (int i = 0; i < 1000; i++) rand_cycle((i < 500) ? 5 : 60);
    idle_all(); repeat (8) step();
    check("drain_mem_q", mem_q.size(), 0);
    check("drain_rd_q", rd_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fb_port_arbiter.md
# fb_port_arbiter

Single-port frame-buffer memory arbiter for the Vegetable Viking display path. Three requesters share one memory port: VGA scanline fetch (read-only), the sprite blitter, and the NIOS CPU bridge. VGA has strict priority; blitter and CPU alternate round-robin, with an optional bounded blitter burst lock. The block registers the memory command and routes read data back to the issuing requester through a fixed-latency tag pipeline.

## Interface
- AW, 20: address width (words)
- DW, 16: data width
- RD_LAT, 2: memory read latency, cycles from mem command edge to valid mem_rdata (≥1)
- BURST_MAX, 8: maximum consecutive blitter grants under lock (≥1)

- Clk  in  1  system clock (50 MHz)
- Reset_n  in  1  asynchronous, active-low reset
- vga_req / vga_addr  in  1 / AW  VGA read request and address
- vga_gnt / vga_rvalid  out  1 / 1  grant and read-data-valid
- blt_req, blt_we, blt_lock  in  1 each  blitter request, write, and burst-lock request
- blt_addr / blt_wdata  in  AW / DW  blitter address and write data
- blt_gnt / blt_rvalid  out  1 / 1  grant and read-data-valid
- cpu_req, cpu_we  in  1 each  CPU request and write
- cpu_addr / cpu_wdata  in  AW / DW  CPU address and write data
- cpu_gnt / cpu_rvalid  out  1 / 1  grant and read-data-valid
- rdata  out  DW  shared read data; qualify with the *_rvalid signals
- mem_ce, mem_we  out  1 each  registered memory command
- mem_addr / mem_wdata  out  AW / DW  registered memory address and write data
- mem_rdata  in  DW  memory read data

## Operation
- A transfer occurs in any cycle where req and gnt are both high.
- At most one gnt is high per cycle.
- Requesters hold req, addr, we and wdata stable until they are granted.
- Grant is combinational from the current req values and the registered state. Priority order:
  1. vga_req wins unconditionally.
  2. Otherwise, in LOCK: the blitter if blt_req.
  3. Otherwise: the round-robin preferred requester if it requests, else the other one.
- FSM states:
  - RR_BLT: blitter preferred. A CPU grant moves to RR_BLT. A blitter grant moves to RR_CPU, unless blt_lock=1, which moves to LOCK.
  - RR_CPU: CPU preferred. Same transitions as RR_BLT.
  - LOCK: excludes the CPU. burst_cnt counts blitter grants, including the one that entered LOCK. Exit to RR_CPU when any of these holds:
    - blt_lock=0 on a blitter grant
    - burst_cnt reaches BURST_MAX
    - blt_req=0 in a cycle without a VGA grant
- VGA grants do not change the FSM state or burst_cnt. A VGA preemption therefore does not end a lock.
- Any non-VGA grant in LOCK is a blitter grant.
- Writes are fire-and-forget; no completion is signalled.
- vga_we is implicitly 0.
- Reads push a tag (ID_VGA/ID_BLT/ID_CPU) into the tag pipeline; a write or idle cycle pushes ID_NONE.
- *_rvalid is asserted for exactly one cycle, for the requester named by the pipeline output tag. rdata equals mem_rdata in that cycle.

## Timing
- Grant in cycle N → mem_* driven from cycle N+1, with mem_ce=1 for exactly one cycle.
- If there is no grant, mem_ce=0 and mem_we=0; mem_addr and mem_wdata hold their last values.
- Read granted in cycle N → rvalid and rdata in cycle N+1+RD_LAT.
- Throughput is one access per cycle; back-to-back reads return in order.
- Reset values:
  - FSM = RR_BLT, burst_cnt = 0
  - mem_ce, mem_we, mem_addr, mem_wdata = 0
  - all *_rvalid = 0, tag pipeline = ID_NONE
  - all gnt forced to 0 while Reset_n=0
- Reset mid-operation discards in-flight reads; no rvalid is produced for them after release.
- burst_cnt width is $clog2(BURST_MAX+1). It clears on every exit from LOCK.
- With all requests asserted every cycle, the CPU is starved only while vga_req is continuous. The blitter-to-CPU gap is bounded by BURST_MAX non-VGA grants.

## Structure
- fb_arb_pkg holds:
  - req_id_t: 2-bit enum ID_NONE/ID_VGA/ID_BLT/ID_CPU
  - arb_state_t: RR_BLT/RR_CPU/LOCK
- Sub-module fb_rd_tag_pipe: RD_LAT+1-deep shift register of req_id_t with asynchronous clear. It outputs the head tag, which is decoded into the three rvalids.

## Test plan
- Reset, then cpu_req=1 read at 0x00010 → cpu_gnt same cycle; mem_ce=1, mem_addr=0x00010 next cycle; cpu_rvalid with rdata equal to the memory model's value 3 cycles after the grant (RD_LAT=2).
- vga_req, blt_req and cpu_req held high for 6 cycles, blt_lock=0 → grants VGA×6. Then drop vga_req → grants alternate BLT, CPU, BLT, CPU.
- blt_lock=1 with blt_req and cpu_req held → exactly 8 consecutive blt_gnt, then cpu_gnt. A VGA request inserted mid-burst takes one cycle and the burst still totals 8 blitter grants.
- Interleaved reads: VGA 0x100, CPU 0x200, VGA 0x101 on consecutive cycles → vga_rvalid, cpu_rvalid, vga_rvalid in order with matching data.
- Blitter write 0x3FF/0xBEEF → mem_we=1, mem_wdata=0xBEEF for one cycle; no blt_rvalid.
- Assert Reset_n=0 one cycle after a CPU read grant, then release → no cpu_rvalid; all outputs at reset values; FSM restarts in RR_BLT.
